// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM states and elaboration-time helpers for the radix-2 FFT engine.
package fft_pkg;
   localparam int MAX_LW = 10;
   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic logic [MAX_LW-1:0] bit_reverse(input logic [MAX_LW-1:0] v, input int w);
      logic [MAX_LW-1:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction
   // W^k = cos - j*sin in Q1.(w-1), rounded to nearest; k=0 is never read (bypassed)
   function automatic int twiddle(input int k, input int n, input int w, input bit im);
      real a, v;
      a = 6.283185307179586 * real'(k) / real'(n);
      v = im ? -$sin(a) : $cos(a);
      return (k == 0) ? 0 : $rtoi($floor(v * (2.0 ** (w - 1)) + 0.5));
   endfunction
endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational radix-2 DIT butterfly, A'=(A+BW)/2, B'=(A-BW)/2.
module fft_butterfly #(
   parameter int DATA_W = 16,
   parameter int TW_W = 16
) (
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   input  logic signed [TW_W-1:0]   w_re,
   input  logic signed [TW_W-1:0]   w_im,
   input  logic                     k0,
   output logic signed [DATA_W-1:0] ya_re,
   output logic signed [DATA_W-1:0] ya_im,
   output logic signed [DATA_W-1:0] yb_re,
   output logic signed [DATA_W-1:0] yb_im
);
   localparam int PW = DATA_W + TW_W + 1;
   localparam int TD = DATA_W + 2;
   localparam int SW = DATA_W + 3;
   localparam logic signed [PW-1:0] RND = PW'(1) << (TW_W - 2);
   logic signed [PW-1:0] p_re, p_im;
   logic signed [TD-1:0] t_re, t_im;
   logic signed [SW-1:0] sa_re, sa_im, sb_re, sb_im;
   always_comb begin
      p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
      p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;
      t_re = k0 ? TD'(b_re) : TD'(p_re >>> (TW_W - 1));
      t_im = k0 ? TD'(b_im) : TD'(p_im >>> (TW_W - 1));
      sa_re = SW'(a_re) + SW'(t_re);
      sa_im = SW'(a_im) + SW'(t_im);
      sb_re = SW'(a_re) - SW'(t_re);
      sb_im = SW'(a_im) - SW'(t_im);
      ya_re = DATA_W'(sa_re >>> 1);
      ya_im = DATA_W'(sa_im >>> 1);
      yb_re = DATA_W'(sb_re >>> 1);
      yb_im = DATA_W'(sb_im >>> 1);
   end
endmodule

// File: rtl/fft_radix2_seq.sv
// fft_radix2_seq: in-place sequential N-point radix-2 DIT FFT, one butterfly per cycle,
// bit-reversed load, natural-order unload with backpressure; output scaled by 1/N.
module fft_radix2_seq import fft_pkg::*; #(
   parameter int N_POINTS = 8,
   parameter int DATA_W = 16,
   parameter int TW_W = 16,
   parameter bit IN_UNSIGNED = 1'b1
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic [DATA_W-1:0]           In_Data,
   input  logic                        In_Valid,
   output logic                        In_Ready,
   output logic [DATA_W-1:0]           Out_Re,
   output logic [DATA_W-1:0]           Out_Im,
   output logic [clog2(N_POINTS)-1:0]  Out_Idx,
   output logic                        Out_Valid,
   input  logic                        Out_Ready,
   output logic                        Out_Last,
   output logic                        Busy
);
   localparam int LW = clog2(N_POINTS);
   localparam int NB = N_POINTS / 2;
   state_t state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d, stage_q, stage_d;
   logic signed [DATA_W-1:0] re_q [N_POINTS];
   logic signed [DATA_W-1:0] im_q [N_POINTS];
   logic signed [DATA_W-1:0] re_d [N_POINTS];
   logic signed [DATA_W-1:0] im_d [N_POINTS];
   logic signed [TW_W-1:0] tw_re [NB];
   logic signed [TW_W-1:0] tw_im [NB];
   logic [LW-1:0] jw, half, pos, addr_a, addr_b, load_addr;
   logic [LW-2:0] tw_k;
   logic in_fire, last_b;
   logic signed [DATA_W-1:0] in_s, ya_re, ya_im, yb_re, yb_im;

   for (genvar k = 0; k < NB; k++) begin : g_tw
      assign tw_re[k] = TW_W'(twiddle(k, N_POINTS, TW_W, 1'b0));
      assign tw_im[k] = TW_W'(twiddle(k, N_POINTS, TW_W, 1'b1));
   end

   // stage s pairs a and a+2^s; a = group*2^(s+1) + pos, twiddle index pos*N/2^(s+1)
   always_comb begin
      jw = {1'b0, cnt_q[LW-2:0]};
      half = LW'(1) << stage_q;
      pos = jw & (half - 1'b1);
      addr_a = ((jw - pos) << 1) | pos;
      addr_b = addr_a | half;
      tw_k = (LW-1)'(pos << (LW - 1 - int'(stage_q)));
      load_addr = LW'(bit_reverse(MAX_LW'(cnt_q), LW));
      in_s = IN_UNSIGNED ? {~In_Data[DATA_W-1], In_Data[DATA_W-2:0]} : In_Data;
   end

   assign last_b = &cnt_q[LW-2:0];

   fft_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bfly (
      .a_re(re_q[addr_a]), .a_im(im_q[addr_a]),
      .b_re(re_q[addr_b]), .b_im(im_q[addr_b]),
      .w_re(tw_re[tw_k]), .w_im(tw_im[tw_k]), .k0(tw_k == '0),
      .ya_re(ya_re), .ya_im(ya_im), .yb_re(yb_re), .yb_im(yb_im)
   );

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      stage_d = stage_q;
      In_Ready = 1'b0;
      Out_Valid = 1'b0;
      in_fire = 1'b0;
      case (state_q)
         S_LOAD: begin
            In_Ready = !Rst;
            in_fire = In_Valid;
            if (in_fire) begin
               cnt_d = cnt_q + 1'b1;
               state_d = (cnt_q == LW'(N_POINTS - 1)) ? S_COMPUTE : S_LOAD;
            end
         end
         S_COMPUTE: begin
            cnt_d = last_b ? '0 : cnt_q + 1'b1;
            if (last_b) begin
               stage_d = (stage_q == LW'(LW - 1)) ? '0 : stage_q + 1'b1;
               state_d = (stage_q == LW'(LW - 1)) ? S_UNLOAD : S_COMPUTE;
            end
         end
         S_UNLOAD: begin
            Out_Valid = 1'b1;
            if (Out_Ready) begin
               cnt_d = cnt_q + 1'b1;
               state_d = (cnt_q == LW'(N_POINTS - 1)) ? S_LOAD : S_UNLOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_comb begin
      re_d = re_q;
      im_d = im_q;
      if (in_fire) begin
         re_d[load_addr] = in_s;
         im_d[load_addr] = '0;
      end
      if (state_q == S_COMPUTE) begin
         re_d[addr_a] = ya_re;
         im_d[addr_a] = ya_im;
         re_d[addr_b] = yb_re;
         im_d[addr_b] = yb_im;
      end
   end

   assign Busy = state_q != S_LOAD;
   assign Out_Idx = Out_Valid ? cnt_q : '0;
   assign Out_Last = Out_Valid && (cnt_q == LW'(N_POINTS - 1));
   assign Out_Re = Out_Valid ? re_q[cnt_q] : '0;
   assign Out_Im = Out_Valid ? im_q[cnt_q] : '0;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_LOAD;
         cnt_q <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         stage_q <= stage_d;
      end
   end

   always_ff @(posedge Clk) begin
      re_q <= re_d;
      im_q <= im_d;
   end
endmodule

// File: tb/tb_fft_radix2_seq.sv
// tb_fft_radix2_seq: signed and unsigned-input engines fed the same frames, checked
// against directed constants and a textbook scaled DIT FFT model.
module tb_fft_radix2_seq;
   localparam int N = 8;
   localparam int DW = 16;
   localparam int LW = 3;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] din_s = '0, din_u = '0;
   logic rdy_s, rdy_u, ov_s, ov_u, last_s, last_u, busy_s, busy_u;
   logic signed [DW-1:0] re_s, im_s, re_u, im_u;
   logic [LW-1:0] idx_s, idx_u;
   int n_assert = 0, n_fail = 0;
   longint x [N];
   longint exp_re [N];
   longint exp_im [N];

   always #5 clk = ~clk;

   fft_radix2_seq #(.N_POINTS(N), .DATA_W(DW), .TW_W(16), .IN_UNSIGNED(1'b0)) u_s (
      .Clk(clk), .Rst(rst), .In_Data(din_s), .In_Valid(in_valid), .In_Ready(rdy_s),
      .Out_Re(re_s), .Out_Im(im_s), .Out_Idx(idx_s), .Out_Valid(ov_s),
      .Out_Ready(out_ready), .Out_Last(last_s), .Busy(busy_s));
   fft_radix2_seq #(.N_POINTS(N), .DATA_W(DW), .TW_W(16), .IN_UNSIGNED(1'b1)) u_u (
      .Clk(clk), .Rst(rst), .In_Data(din_u), .In_Valid(in_valid), .In_Ready(rdy_u),
      .Out_Re(re_u), .Out_Im(im_u), .Out_Idx(idx_u), .Out_Valid(ov_u),
      .Out_Ready(out_ready), .Out_Last(last_u), .Busy(busy_u));

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic longint tw(input int k, input bit im);
      real a, v;
      a = 2.0 * 3.141592653589793 * real'(k) / real'(N);
      v = im ? -$sin(a) : $cos(a);
      return longint'($rtoi($floor(v * 32768.0 + 0.5)));
   endfunction

   function automatic longint wrap(input longint v);
      logic signed [DW-1:0] t;
      t = v[DW-1:0];
      return longint'(t);
   endfunction

   // Cooley-Tukey DIT: merge sub-transforms of size m/2 into size m, halving each merge
   function automatic void model();
      longint ar [N];
      longint ai [N];
      longint tr, ti, er, ei;
      int r, v, e, o, kk;
      for (int i = 0; i < N; i++) begin
         r = 0;
         v = i;
         for (int b = 0; b < LW; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
         end
         ar[r] = x[i];
         ai[r] = 0;
      end
      for (int m = 2; m <= N; m *= 2)
         for (int s0 = 0; s0 < N; s0 += m)
            for (int k = 0; k < m / 2; k++) begin
               e = s0 + k;
               o = e + m / 2;
               kk = k * (N / m);
               if (kk == 0) begin
                  tr = ar[o];
                  ti = ai[o];
               end else begin
                  tr = (ar[o] * tw(kk, 0) - ai[o] * tw(kk, 1) + 16384) >>> 15;
                  ti = (ar[o] * tw(kk, 1) + ai[o] * tw(kk, 0) + 16384) >>> 15;
               end
               er = ar[e];
               ei = ai[e];
               ar[e] = wrap((er + tr) >>> 1);
               ai[e] = wrap((ei + ti) >>> 1);
               ar[o] = wrap((er - tr) >>> 1);
               ai[o] = wrap((ei - ti) >>> 1);
            end
      for (int i = 0; i < N; i++) begin
         exp_re[i] = ar[i];
         exp_im[i] = ai[i];
      end
   endfunction

   task automatic set_exp(input int which, input longint val, input longint other);
      for (int i = 0; i < N; i++) begin
         exp_re[i] = (i == which) ? val : other;
         exp_im[i] = 0;
      end
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            din_s = 16'($urandom);
            din_u = din_s;
            @(posedge clk); #1;
         end
         din_s = x[i][DW-1:0];
         din_u = din_s ^ 16'h8000;
         in_valid = 1'b1;
         @(negedge clk);
         chk("in_ready_load", rdy_s, 1);
         chk("in_ready_load_u", rdy_u, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input bit junk);
      int cyc;
      cyc = 0;
      in_valid = junk;
      out_ready = junk;
      din_s = 16'h1234;
      din_u = 16'h5678;
      while (ov_s !== 1'b1 && cyc < 40) begin
         chk("busy_compute", busy_s, 1);
         chk("in_ready_compute", rdy_s, 0);
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("latency", cyc, 12);
   endtask

   task automatic recv_frame(input int mode);
      int got, cyc;
      bit hs;
      got = 0;
      cyc = 0;
      while (got < N && cyc < 200) begin
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("out_valid", ov_s, 1);
         chk("out_valid_u", ov_u, 1);
         chk("out_idx", idx_s, got);
         chk("out_idx_u", idx_u, got);
         chk("out_re", re_s, exp_re[got]);
         chk("out_im", im_s, exp_im[got]);
         chk("out_re_u", re_u, exp_re[got]);
         chk("out_im_u", im_u, exp_im[got]);
         chk("out_last", last_s, got == N - 1);
         chk("in_ready_unload", rdy_s, 0);
         chk("busy_unload", busy_s, 1);
         hs = out_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) got++;
      end
      out_ready = 1'b0;
      chk("bins_delivered", got, N);
      @(negedge clk);
      chk("in_ready_after", rdy_s, 1);
      chk("out_valid_after", ov_s, 0);
      chk("busy_after", busy_s, 0);
      chk("last_after", last_s, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", ov_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_in_ready", rdy_s, 0);
      chk("rst_out_idx", idx_s, 0);
      chk("rst_out_re", re_s, 0);
      chk("rst_out_im", im_s, 0);
      chk("rst_out_last", last_s, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < N; i++) x[i] = (i == 0) ? 8000 : 0;
      set_exp(0, 1000, 1000);
      send_frame(0);
      wait_out(0);
      recv_frame(0);

      for (int i = 0; i < N; i++) x[i] = 1000;
      set_exp(0, 1000, 0);
      send_frame(1);
      wait_out(1);
      recv_frame(1);

      for (int i = 0; i < N; i++) x[i] = (i % 2 == 1) ? -800 : 800;
      set_exp(4, 800, 0);
      send_frame(0);
      wait_out(0);
      recv_frame(0);

      for (int i = 0; i < N; i++) x[i] = 0;
      set_exp(0, 0, 0);
      send_frame(0);
      wait_out(1);
      recv_frame(2);

      for (int i = 0; i < N; i++) x[i] = 8000;
      set_exp(0, 8000, 0);
      send_frame(1);
      wait_out(0);
      recv_frame(1);

      for (int i = 0; i < N; i++) x[i] = (i == 0) ? 8000 : 0;
      send_frame(0);
      repeat (5) @(posedge clk);
      #1;
      chk("busy_before_abort", busy_s, 1);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", ov_s, 0);
      chk("abort_busy", busy_s, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", rdy_s, 1);
      chk("abort_busy_after", busy_s, 0);
      chk("abort_out_valid_after", ov_s, 0);
      @(posedge clk); #1;
      set_exp(0, 1000, 1000);
      send_frame(0);
      wait_out(0);
      recv_frame(0);

      repeat (4) begin
         for (int i = 0; i < N; i++) x[i] = longint'($urandom_range(0, 32767)) - 16384;
         model();
         send_frame(1);
         wait_out(1);
         recv_frame(2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
